// File: rtl/mem_readback_tx_pkg.sv
// Shared definitions for the on-chip memory test read/write paths.
//   ADDR_BITS_DEF  : default memory address width (depth = 2**ADDR_BITS_DEF)
//   DATA_BITS_DEF  : default memory word width, a multiple of 8
//   BYTES_PER_WORD : bytes per word at the default width
//   rb_state_e     : readback transmitter FSM states
package mem_test_pkg;

  localparam int ADDR_BITS_DEF  = 5;
  localparam int DATA_BITS_DEF  = 16;
  localparam int BYTES_PER_WORD = DATA_BITS_DEF / 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_LATCH    = 3'd2,
    ST_SEND     = 3'd3,
    ST_WAIT_ACK = 3'd4
  } rb_state_e;

endpackage

// File: rtl/mem_readback_tx_if.sv
// Bundle of the readback transmitter's control, memory read port and host
// handshake signals.
//   slave  : the transmitter side (mem_readback_tx)
//   master : the side that issues start, serves memory data and acks bytes
interface mem_readback_tx_if #(
  parameter int ADDR_BITS = mem_test_pkg::ADDR_BITS_DEF,
  parameter int DATA_BITS = mem_test_pkg::DATA_BITS_DEF
);
  logic                 start;
  logic [ADDR_BITS-1:0] start_addr;
  logic [ADDR_BITS:0]   length;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_re;
  logic [DATA_BITS-1:0] mem_rdata;
  logic [7:0]           tx_data;
  logic                 tx_req;
  logic                 tx_ack_async;
  logic                 busy;
  logic                 done;

  modport slave (
    input  start, start_addr, length, mem_rdata, tx_ack_async,
    output mem_addr, mem_re, tx_data, tx_req, busy, done
  );

  modport master (
    output start, start_addr, length, mem_rdata, tx_ack_async,
    input  mem_addr, mem_re, tx_data, tx_req, busy, done
  );
endinterface

// File: rtl/mem_readback_tx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level/toggle input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output, two clk cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_readback_tx.sv
// Memory readback transmitter: reads a run of words from the memory under
// test and streams them LSB-byte first to an off-chip host with a two-phase
// toggle handshake (tx_req toggles per byte, host echoes on tx_ack_async).
// Optional macro MEM_READBACK_CHECKSUM_EN appends an XOR checksum byte.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start/start_addr/length : run request (length 0 = no words)
//   bus.mem_addr/mem_re/mem_rdata : synchronous memory read port
//   bus.tx_data/tx_req/tx_ack_async : host byte handshake
//   bus.busy/done : run status
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// READ     | mem_re asserted for the current word address
// LATCH    | memory data valid, load it into the shift register
// SEND     | present next byte on tx_data and toggle tx_req
// WAIT_ACK | wait until synchronized ack matches tx_req
module mem_readback_tx
  import mem_test_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_readback_tx_if.slave   bus
);

  localparam int BYTES = DATA_BITS / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  rb_state_e            state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS:0]   remaining_q, remaining_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bytes_left_q, bytes_left_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_req_q, tx_req_d;
  logic                 done_q, done_d;
  logic                 ack_s;
  logic                 in_csum;
`ifdef MEM_READBACK_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
  logic                 csum_phase_q, csum_phase_d;
`endif

  sync_2ff u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.tx_ack_async),
    .q_o   (ack_s)
  );

`ifdef MEM_READBACK_CHECKSUM_EN
  assign in_csum = csum_phase_q;
`else
  assign in_csum = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    shift_d      = shift_q;
    bytes_left_d = bytes_left_q;
    tx_data_d    = tx_data_q;
    tx_req_d     = tx_req_q;
    done_d       = 1'b0;
`ifdef MEM_READBACK_CHECKSUM_EN
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
`ifdef MEM_READBACK_CHECKSUM_EN
          csum_d       = 8'h00;
          csum_phase_d = (bus.length == '0);
`endif
          if (bus.length != '0) begin
            addr_d      = bus.start_addr;
            remaining_d = bus.length;
            state_d     = ST_READ;
          end else begin
`ifdef MEM_READBACK_CHECKSUM_EN
            // empty run still carries the (zero) checksum byte
            state_d = ST_SEND;
`else
            done_d  = 1'b1;
`endif
          end
        end
      end
      ST_READ: state_d = ST_LATCH;
      ST_LATCH: begin
        shift_d      = bus.mem_rdata;
        bytes_left_d = IDX_W'(BYTES - 1);
        state_d      = ST_SEND;
      end
      ST_SEND: begin
        tx_req_d  = ~tx_req_q;
        tx_data_d = shift_q[7:0];
`ifdef MEM_READBACK_CHECKSUM_EN
        if (csum_phase_q) tx_data_d = csum_q;
        else              csum_d    = csum_q ^ shift_q[7:0];
`endif
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_s == tx_req_q) begin
          if (in_csum) begin
`ifdef MEM_READBACK_CHECKSUM_EN
            csum_phase_d = 1'b0;
`endif
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (bytes_left_q != '0) begin
            shift_d      = shift_q >> 8;
            bytes_left_d = bytes_left_q - IDX_W'(1);
            state_d      = ST_SEND;
          end else if (remaining_q > (ADDR_BITS+1)'(1)) begin
            // address wraps naturally at 2**ADDR_BITS
            addr_d      = addr_q + ADDR_BITS'(1);
            remaining_d = remaining_q - (ADDR_BITS+1)'(1);
            state_d     = ST_READ;
          end else begin
`ifdef MEM_READBACK_CHECKSUM_EN
            csum_phase_d = 1'b1;
            state_d      = ST_SEND;
`else
            done_d  = 1'b1;
            state_d = ST_IDLE;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      shift_q      <= '0;
      bytes_left_q <= '0;
      tx_data_q    <= 8'h00;
      tx_req_q     <= 1'b0;
      done_q       <= 1'b0;
`ifdef MEM_READBACK_CHECKSUM_EN
      csum_q       <= 8'h00;
      csum_phase_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      shift_q      <= shift_d;
      bytes_left_q <= bytes_left_d;
      tx_data_q    <= tx_data_d;
      tx_req_q     <= tx_req_d;
      done_q       <= done_d;
`ifdef MEM_READBACK_CHECKSUM_EN
      csum_q       <= csum_d;
      csum_phase_q <= csum_phase_d;
`endif
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.mem_re   = (state_q == ST_READ);
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_req   = tx_req_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_mem_readback_tx.sv
module tb_mem_readback_tx;
  localparam int AB = 5;
  localparam int DB = 16;
  localparam int NB = DB / 8;
  localparam int DEPTH = 1 << AB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_readback_tx_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  mem_readback_tx #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DB-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_bytes[$];
  int exp_addr[$];
  int done_cnt = 0;
  int bytes_seen = 0;
  int ack_min = 0;
  int ack_max = 3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // reference model: byte stream and read addresses of a run
  task automatic build_expected(input int a, input int len);
    logic [DB-1:0] w;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back((a + i) % DEPTH);
      w = mem[(a + i) % DEPTH];
      for (int b = 0; b < NB; b++) begin
        exp_bytes.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
`ifdef MEM_READBACK_CHECKSUM_EN
    exp_bytes.push_back(x);
`endif
  endtask

  // host: scoreboards each new byte, holds ack off for a random time,
  // and checks tx_data stays put while waiting
  initial begin
    logic last_req, pending, unstable;
    logic [7:0] held;
    int wait_left;
    bus.tx_ack_async = 1'b0;
    last_req = 1'b0; pending = 1'b0; unstable = 1'b0; held = 8'h00; wait_left = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_req = 1'b0; pending = 1'b0; bus.tx_ack_async = 1'b0;
      end else begin
        if (pending) begin
          if (bus.tx_data !== held) unstable = 1'b1;
          if (wait_left <= 0) begin
            chk("tx_data_stable", {31'd0, unstable}, 32'd0);
            bus.tx_ack_async = last_req;
            pending = 1'b0;
          end else wait_left--;
        end
        if (bus.tx_req !== last_req) begin
          last_req = bus.tx_req;
          bytes_seen++;
          if (exp_bytes.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_byte actual=%0h expected=none", bus.tx_data);
          end else chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_bytes.pop_front()});
          held = bus.tx_data; unstable = 1'b0; pending = 1'b1;
          wait_left = $urandom_range(ack_max, ack_min);
        end
      end
    end
  end

  // memory read address and done monitors
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.mem_re) begin
      if (exp_addr.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_read actual=%0h expected=none", bus.mem_addr);
      end else chk("mem_addr", {27'd0, bus.mem_addr}, exp_addr.pop_front());
    end
    if (rst_n && bus.done) done_cnt++;
  end

  task automatic do_run(input int a, input int len, input bit busy_start);
    int d0, lat, t;
    logic r0;
    build_expected(a, len);
    d0 = done_cnt;
    r0 = bus.tx_req;
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = AB'(a); bus.length = (AB+1)'(len);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    if (len != 0) begin
      while (bus.tx_req === r0 && lat < 20) begin @(negedge clk); lat++; end
      chk("start_to_req_cycles", lat, 4);
    end else begin
`ifndef MEM_READBACK_CHECKSUM_EN
      chk("len0_done_next", {31'd0, bus.done}, 32'd1);
      chk("len0_busy", {31'd0, bus.busy}, 32'd0);
`endif
    end
    if (busy_start) begin
      repeat (5) @(negedge clk);
      chk("busy_during_run", {31'd0, bus.busy}, 32'd1);
      bus.start = 1'b1; bus.start_addr = AB'(0); bus.length = (AB+1)'(5);
      @(negedge clk);
      bus.start = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 5000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
    chk("bytes_left", exp_bytes.size(), 0);
    chk("reads_left", exp_addr.size(), 0);
`ifndef MEM_READBACK_CHECKSUM_EN
    if (len == 0) chk("len0_req_unchanged", {31'd0, bus.tx_req}, {31'd0, r0});
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, t;
    bus.start = 1'b0; bus.start_addr = '0; bus.length = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DB'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_tx_req", {31'd0, bus.tx_req}, 0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 0);
    chk("rst_mem_re", {31'd0, bus.mem_re}, 0);
    chk("rst_mem_addr", {27'd0, bus.mem_addr}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mem[3] = 16'hBEEF; mem[4] = 16'h1234;
    do_run(3, 2, 1'b0);
    mem[31] = 16'h0001; mem[0] = 16'h0002;
    do_run(31, 2, 1'b0);
    do_run(5, 0, 1'b0);

    ack_min = 20; ack_max = 20;
    do_run(10, 2, 1'b1);

    // reset after the first of two bytes of a word
    ack_min = 10; ack_max = 10;
    build_expected(7, 1);
    b0 = bytes_seen;
    @(negedge clk);
    bus.start = 1'b1; bus.start_addr = AB'(7); bus.length = (AB+1)'(1);
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while (bytes_seen == b0 && t < 50) begin @(negedge clk); t++; end
    chk("first_byte_before_reset", bytes_seen - b0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_req", {31'd0, bus.tx_req}, 0);
    chk("midrst_tx_data", {24'd0, bus.tx_data}, 0);
    chk("midrst_busy", {31'd0, bus.busy}, 0);
    chk("midrst_mem_re", {31'd0, bus.mem_re}, 0);
    chk("midrst_done", {31'd0, bus.done}, 0);
    exp_bytes.delete();
    exp_addr.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_min = 0; ack_max = 3;
    do_run(7, 1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DB'($urandom);
      if (r == 3)      do_run($urandom_range(DEPTH-1, 0), DEPTH, 1'b0);
      else if (r == 5) do_run($urandom_range(DEPTH-1, 0), 0, 1'b0);
      else             do_run($urandom_range(DEPTH-1, 0), $urandom_range(6, 1), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
